timer_peripheral: RTL and testbench
===================================

// Module: timer_peripheral
// PURPOSE
//  Memory-mapped peripheral block downstream of the single-cycle CPU datapath, beside the data
//  memory: decodes the CPU's data-side bus (ALU address, rt write data, MemRead/MemWrite) for
//  0x4000_00xx and returns read data the same cycle. Holds a reloadable 32-bit timer with
//  prescaler and interrupt flag, an LED register, a 7-segment register and a free-running SysTick.
// PARAMETERS
//  PRESCALE  1   clock cycles per timer increment (>=1); 1 = count every clock
//  LED_W     8   width of led output
//  DIGI_W    12  width of digi output (4 anode + 8 segment bits)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high
//  addr       in   32      byte address from CPU ALU result
//  wdata      in   32      store data from CPU (rt register)
//  mem_read   in   1       CPU load strobe
//  mem_write  in   1       CPU store strobe
//  sel        out  1       addr hits peripheral space; CPU muxes rdata over data-memory output
//  rdata      out  32      read data, combinational
//  led        out  LED_W   LED register
//  digi       out  DIGI_W  7-segment register
//  irq        out  1       timer interrupt, TCON[1] & TCON[2]
// BEHAVIOUR
//  Reset (async, immediate): TH=0, TL=0, TCON=0, LED=0, DIGI=0, SYSTICK=0, prescale cnt=0.
//   Hence irq=0, led=0, digi=0. Reset mid-count or mid-store discards the operation.
//  Decode: sel = (addr[31:8]==24'h400000) && addr[1:0]==0 && addr[7:0]<=8'h14.
//   Word map by addr[7:0]:
//    00 TH reload (RW)      04 TL counter (RW)    08 TCON[2:0] (RW)
//    0C LED (RW)            10 DIGI (RW)          14 SYSTICK (RO, writes ignored)
//  Read: rdata = selected register, zero-extended, when sel && mem_read; else 32'h0.
//   Zero latency; stores or ticks in this cycle appear only after the edge.
//  Write: on rising clk when sel && mem_write; unmapped or misaligned stores are ignored.
//   LED/DIGI take wdata[LED_W-1:0]/wdata[DIGI_W-1:0].
//  TCON: bit0 = enable, bit1 = irq enable, bit2 = irq status (sticky; software clears by
//   writing 0; writing 1 does not set it).
//  Prescaler: when TCON[0]=1, pcnt counts 0..PRESCALE-1 and wraps; tick = enable && pcnt==PRESCALE-1.
//   pcnt holds while disabled and clears on any TCON write.
//  Timer on tick:
//   - TL!=32'hFFFF_FFFF: TL <= TL+1.
//   - TL==32'hFFFF_FFFF: TL <= TH (reload, no increment in the same cycle), and TCON[2] <= 1
//     if TCON[1]=1.
//  Simultaneous events:
//   - CPU write to TL in a tick cycle: written value wins, no increment.
//   - CPU write to TCON in an overflow cycle: written bits 1:0 take effect; bit2 ends 1
//     (hardware set beats software clear).
//   - Write to TH in an overflow cycle: the reload uses the old TH.
//  SYSTICK increments every clock, wraps FFFF_FFFF->0, and is unaffected by TCON.
//  irq is registered-state combinational (no extra delay); it stays high until cleared.
// TESTING
//  1 reset asserted mid-count (TL=5, TCON=3) -> next sample TL=0, TCON=0, irq=0, led=0 with no clk edge.
//  2 store 0xA5 to 0x4000000C, then load 0x4000000C -> led=8'hA5, rdata=32'hA5, sel=1;
//    load 0x10000000 -> sel=0, rdata=0.
//  3 PRESCALE=1, TH=FFFF_FFF0, TL=FFFF_FFFE, TCON=3 -> after 2 clk TL=FFFF_FFF0 and irq=1;
//    store 0 to TCON[2] (wdata=3) -> irq=0.
//  4 PRESCALE=4, TL=0, TCON=1 -> TL=1 after clk 4, TL=2 after clk 8; TCON=0 -> TL holds.
//  5 at overflow edge, store TCON=wdata 3 -> TCON reads 7; store TL=0x10 in a tick cycle -> TL=0x10.
//  6 store 0x1234 to 0x40000014 -> SYSTICK keeps counting (reads reset-cycles, not 0x1234);
//    store to 0x40000018 or 0x40000002 -> no register changes.

Source files
------------

// File: rtl/timer_peripheral_if.sv
// CPU data-side bus into the timer peripheral.
// Load data comes back in the same cycle as the request.
interface timer_peripheral_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        sel;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, mem_read, mem_write,
    input  sel, rdata
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write,
    output sel, rdata
  );
endinterface

// File: rtl/timer_peripheral.sv
// Memory-mapped timer, LED, 7-seg and SysTick block.
// Registers are decoded at 0x4000_0000..0x4000_0014.
module timer_peripheral #(
  parameter int PRESCALE = 1,
  parameter int LED_W    = 8,
  parameter int DIGI_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  timer_peripheral_if.slave bus,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [31:0]       th_q, th_d;
  logic [31:0]       tl_q, tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [31:0]       tick_q, tick_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;

  logic       hit;
  logic [2:0] idx;
  logic       wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic       tick, ovf;

  // Address decode and per-register write strobes
  always_comb begin
    hit = (bus.addr[31:8] == 24'h400000)
       && (bus.addr[1:0] == 2'b00)
       && (bus.addr[7:0] <= 8'h14);
    idx     = bus.addr[4:2];
    wr_th   = hit && bus.mem_write && (idx == 3'd0);
    wr_tl   = hit && bus.mem_write && (idx == 3'd1);
    wr_tcon = hit && bus.mem_write && (idx == 3'd2);
    wr_led  = hit && bus.mem_write && (idx == 3'd3);
    wr_digi = hit && bus.mem_write && (idx == 3'd4);
  end

  // Same-cycle read mux, zero when not a mapped load
  always_comb begin
    bus.rdata = 32'h0;
    if (hit && bus.mem_read) begin
      unique case (idx)
        3'd0:    bus.rdata = th_q;
        3'd1:    bus.rdata = tl_q;
        3'd2:    bus.rdata = {29'h0, tcon_q};
        3'd3:    bus.rdata = 32'(led_q);
        3'd4:    bus.rdata = 32'(digi_q);
        3'd5:    bus.rdata = tick_q;
        default: bus.rdata = 32'h0;
      endcase
    end
  end

  // Next-state: prescaler, timer with reload, control and output registers
  always_comb begin
    tick = tcon_q[0] && (pcnt_q == PMAX);
    ovf  = tick && (tl_q == 32'hFFFF_FFFF);

    pcnt_d = pcnt_q;
    if (wr_tcon)        pcnt_d = '0;
    else if (tcon_q[0]) pcnt_d = (pcnt_q == PMAX) ? '0 : pcnt_q + PW'(1);

    th_d = wr_th ? bus.wdata : th_q;

    tl_d = tl_q;
    if (wr_tl)    tl_d = bus.wdata;
    else if (ovf) tl_d = th_q;
    else if (tick) tl_d = tl_q + 32'd1;

    // Status bit only clears by software; an overflow set always wins
    tcon_d = tcon_q;
    if (wr_tcon) begin
      tcon_d[1:0] = bus.wdata[1:0];
      tcon_d[2]   = tcon_q[2] & bus.wdata[2];
    end
    if (ovf && tcon_q[1]) tcon_d[2] = 1'b1;

    led_d  = wr_led  ? bus.wdata[LED_W-1:0]  : led_q;
    digi_d = wr_digi ? bus.wdata[DIGI_W-1:0] : digi_q;
    tick_d = tick_q + 32'd1;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      led_q  <= '0;
      digi_q <= '0;
      tick_q <= '0;
      pcnt_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      tick_q <= tick_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign bus.sel = hit;
  assign led     = led_q;
  assign digi    = digi_q;
  assign irq     = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral with PRESCALE=1 and PRESCALE=4.
// Load results are queued when issued and checked on return.
module tb_timer_peripheral;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;

  logic [7:0]  led1, led4;
  logic [11:0] digi1, digi4;
  logic        irq1, irq4;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cyc;
  logic [32:0] sb_q[$];

  timer_peripheral_if bus1();
  timer_peripheral_if bus4();

  assign bus1.addr      = addr;
  assign bus1.wdata     = wdata;
  assign bus1.mem_read  = mem_read;
  assign bus1.mem_write = mem_write;
  assign bus4.addr      = addr;
  assign bus4.wdata     = wdata;
  assign bus4.mem_read  = mem_read;
  assign bus4.mem_write = mem_write;

  timer_peripheral #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .led(led1), .digi(digi1), .irq(irq1)
  );

  timer_peripheral #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave),
    .led(led4), .digi(digi4), .irq(irq4)
  );

  always #5 clk = ~clk;

  // Clocks seen since reset release: expected SysTick value
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  task automatic chk(input string tag,
                     input logic [32:0] obs,
                     input logic [32:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input string tag, input int which,
                    input logic [31:0] a,
                    input logic esel, input logic [31:0] exp);
    logic [32:0] got;
    logic [32:0] want;
    addr = a;
    mem_read = 1'b1;
    sb_q.push_back({esel, exp});
    #1;
    got = (which == 4) ? {bus4.sel, bus4.rdata}
                       : {bus1.sel, bus1.rdata};
    want = sb_q.pop_front();
    chk(tag, got, want);
    mem_read = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_led", 33'(led1), 33'h0);
    chk("rst_digi", 33'(digi1), 33'h0);
    chk("rst_irq", 33'(irq1), 33'h0);
    rd("rst_tl", 1, A_TL, 1'b1, 32'h0);

    // Reset while counting
    wr(A_TL, 32'd5);
    wr(A_TCON, 32'd3);
    wr(A_LED, 32'h3C);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    rd("arst_tl", 1, A_TL, 1'b1, 32'h0);
    rd("arst_tcon", 1, A_TCON, 1'b1, 32'h0);
    chk("arst_irq", 33'(irq1), 33'h0);
    chk("arst_led", 33'(led1), 33'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LED store/load, unmapped load
    wr(A_LED, 32'hA5);
    chk("led_out", 33'(led1), 33'hA5);
    rd("led_rd", 1, A_LED, 1'b1, 32'hA5);
    rd("unmapped", 1, 32'h1000_0000, 1'b0, 32'h0);
    addr = A_LED;
    #1;
    chk("no_read", {bus1.sel, bus1.rdata}, {1'b1, 32'h0});
    wr(A_LED, 32'hFFFF_F15A);
    rd("led_trunc", 1, A_LED, 1'b1, 32'h5A);
    wr(A_DIGI, 32'hFFFF_FABC);
    chk("digi_out", 33'(digi1), 33'hABC);
    rd("digi_rd", 1, A_DIGI, 1'b1, 32'hABC);

    // Overflow reload and irq
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd("ovf_pre", 1, A_TL, 1'b1, 32'hFFFF_FFFE);
    chk("irq_pre", 33'(irq1), 33'h0);
    repeat (2) @(posedge clk);
    #1;
    rd("ovf_tl", 1, A_TL, 1'b1, 32'hFFFF_FFF0);
    chk("irq_set", 33'(irq1), 33'h1);
    rd("ovf_tcon", 1, A_TCON, 1'b1, 32'h7);
    wr(A_TCON, 32'd3);
    chk("irq_clr", 33'(irq1), 33'h0);
    wr(A_TCON, 32'd7);
    rd("no_hw_set", 1, A_TCON, 1'b1, 32'h7 & 32'h3);

    // Clear races an overflow: hardware set wins
    wr(A_TCON, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TCON, 32'd3);
    rd("race_tcon", 1, A_TCON, 1'b1, 32'h7);
    rd("race_tl", 1, A_TL, 1'b1, 32'hFFFF_FFF0);
    wr(A_TL, 32'h10);
    rd("tl_wr_tick", 1, A_TL, 1'b1, 32'h10);

    // TH store in the overflow cycle reloads the old TH
    wr(A_TCON, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd1);
    wr(A_TH, 32'h55);
    rd("th_race_tl", 1, A_TL, 1'b1, 32'hFFFF_FFF0);
    rd("th_race_th", 1, A_TH, 1'b1, 32'h55);
    chk("irq_off", 33'(irq1), 33'h0);
    wr(A_TCON, 32'd0);

    // Prescale by 4
    wr(A_TL, 32'h0);
    wr(A_TCON, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rd("p4_clk3", 4, A_TL, 1'b1, 32'd0);
    @(posedge clk);
    #1;
    rd("p4_clk4", 4, A_TL, 1'b1, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    rd("p4_clk8", 4, A_TL, 1'b1, 32'd2);
    wr(A_TCON, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    rd("p4_hold", 4, A_TL, 1'b1, 32'd2);

    // SysTick is read-only; bad stores change nothing
    wr(A_TICK, 32'h1234);
    rd("systick", 1, A_TICK, 1'b1, cyc);
    repeat (3) @(posedge clk);
    #1;
    rd("systick2", 1, A_TICK, 1'b1, cyc);
    rd("sel_18", 1, 32'h4000_0018, 1'b0, 32'h0);
    wr(32'h4000_0018, 32'hFFFF_FFFF);
    wr(32'h4000_0002, 32'hDEAD_BEEF);
    wr(32'h4000_000D, 32'h0000_00FF);
    rd("keep_th", 1, A_TH, 1'b1, 32'h55);
    rd("keep_led", 1, A_LED, 1'b1, 32'h5A);
    rd("keep_digi", 1, A_DIGI, 1'b1, 32'hABC);
    rd("keep_tcon", 1, A_TCON, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
